// File: rtl/icache_refill_responder.sv
// ----------------------------------------------------------------------------
// icache_refill_responder
//
// Memory-side responder for instruction-cache line refills. A one-cycle
// request carries a word address; the responder reads the enclosing line from
// a byte-wide RAM port (one byte per cycle, 1-cycle read latency), assembles
// it little-endian and returns it with a one-cycle resp_valid pulse.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   rdy         global ready, gates request acceptance only
//   req_valid   one-cycle request pulse
//   req_addr    word address of any word within the wanted line
//   resp_valid  one-cycle pulse, resp_data valid
//   resp_data   assembled line, byte k at bits [8k+7:8k]; held until next refill
//   busy        high while a refill is in progress
//   mem_a       RAM byte address
//   mem_din     RAM read data, valid the cycle after mem_a
//
// Optional feature (macro ICACHE_REFILL_LINE_BUF_EN): remember the tag of the
// last completed line; a request hitting it is answered from resp_data in the
// next cycle without touching the RAM.
// ----------------------------------------------------------------------------
module icache_refill_responder #(
  parameter int ADDR_WIDTH     = 17,
  parameter int LINE_WORDS_LOG = 2,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH + 2,
  parameter int LINE_WIDTH     = 32 * 2**LINE_WORDS_LOG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      req_valid,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  output logic                      resp_valid,
  output logic [LINE_WIDTH-1:0]     resp_data,
  output logic                      busy,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  input  logic [7:0]                mem_din
);

  // Byte offset within a line; the counter wraps naturally after NB bytes.
  localparam int OFS_W = LINE_WORDS_LOG + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                state;
  logic [OFS_W-1:0]          cnt;
  logic [OFS_W-1:0]          byte_idx;
  logic [MEM_ADDR_WIDTH-1:0] base_a;
  logic                      hit;
  logic                      unused_word_bits;

  // Line-aligned byte address: word-within-line bits of the request are dropped.
  assign base_a = MEM_ADDR_WIDTH'({req_addr[ADDR_WIDTH-1:LINE_WORDS_LOG],
                                   {OFS_W{1'b0}}});
  assign unused_word_bits = ^req_addr[LINE_WORDS_LOG-1:0];

  // Data arriving now belongs to the address issued one cycle earlier. In
  // DRAIN the counter has wrapped to 0, so this yields the last byte (NB-1).
  assign byte_idx = cnt - OFS_W'(1);

  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);

`ifdef ICACHE_REFILL_LINE_BUF_EN
  localparam int TAG_W = ADDR_WIDTH - LINE_WORDS_LOG;

  logic [TAG_W-1:0] tag;
  logic             tag_valid;

  assign hit = tag_valid && (tag == req_addr[ADDR_WIDTH-1:LINE_WORDS_LOG]);
`else
  assign hit = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous, sampled only on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_a     <= '0;
      // NOTE: the line register is reset because its cleared value is
      // architecturally visible after reset, unlike a plain data buffer.
      resp_data <= '0;
`ifdef ICACHE_REFILL_LINE_BUF_EN
      tag_valid <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && rdy) begin
            if (hit) begin
              state <= S_DONE;
            end else begin
              state <= S_READ;
              mem_a <= base_a;
              cnt   <= '0;
            end
          end
        end

        S_READ: begin
          if (cnt != '0) begin
            resp_data[{byte_idx, 3'b000} +: 8] <= mem_din;
          end
          cnt <= cnt + OFS_W'(1);
          if (cnt == '1) begin
            state <= S_DRAIN;             // mem_a holds the last byte address
          end else begin
            mem_a <= mem_a + MEM_ADDR_WIDTH'(1);
          end
        end

        S_DRAIN: begin
          resp_data[{byte_idx, 3'b000} +: 8] <= mem_din;
          state <= S_DONE;
`ifdef ICACHE_REFILL_LINE_BUF_EN
          tag       <= mem_a[MEM_ADDR_WIDTH-1:OFS_W];
          tag_valid <= 1'b1;
`endif
        end

        default: begin                    // S_DONE
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_responder.sv
// ----------------------------------------------------------------------------
// Testbench for icache_refill_responder (default parameters).
// A stimulus process issues requests and pushes the expected responses and
// RAM address trace into queues; a monitor on the falling edge pops and
// compares whenever the DUT presents them. RAM content is byte[x] = x[7:0]
// xor a salt that is changed only while the DUT is idle.
// ----------------------------------------------------------------------------
module tb_icache_refill_responder;

  localparam int AW  = 17;
  localparam int MAW = 19;
  localparam int LW  = 128;
  localparam int NB  = 16;

`ifdef ICACHE_REFILL_LINE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  typedef struct {
    int            cyc;
    logic [LW-1:0] data;
  } resp_t;

  typedef struct {
    int             cyc;
    logic [MAW-1:0] addr;
  } addr_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rdy = 1'b1;
  logic           req_valid = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic           resp_valid;
  logic [LW-1:0]  resp_data;
  logic           busy;
  logic [MAW-1:0] mem_a;
  logic [7:0]     mem_din = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  resp_t          rq[$];
  addr_t          aq[$];
  int             busy_lo = 1;
  int             busy_hi = 0;
  logic [7:0]     salt = '0;
  bit             tag_valid = 1'b0;
  logic [AW-3:0]  tag = '0;
  logic [LW-1:0]  held_line = '0;
  logic [MAW-1:0] last_a = '0;
  bit             prev_rv = 1'b0;

  icache_refill_responder dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .mem_a      (mem_a),
    .mem_din    (mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_byte(input logic [MAW-1:0] a);
    return a[7:0] ^ salt;
  endfunction

  // Byte-wide RAM with one cycle of read latency
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  function automatic logic [LW-1:0] line_of(input logic [MAW-1:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NB; k++) l[8*k +: 8] = ram_byte(base + MAW'(k));
    return l;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int gap);
    while (cyc < busy_hi + 1 + gap) tick(1);
  endtask

  task automatic model_reset();
    rq.delete();
    aq.delete();
    busy_lo   = 1;
    busy_hi   = 0;
    tag_valid = 1'b0;
    held_line = '0;
    last_a    = '0;
  endtask

  // Drive a one-cycle request in the current cycle; record what the model
  // says should happen.
  task automatic issue(input logic [AW-1:0] addr, input logic r);
    logic [MAW-1:0] base;
    resp_t          e;
    addr_t          m;
    req_valid = 1'b1;
    req_addr  = addr;
    rdy       = r;
    if (r && !(cyc >= busy_lo && cyc <= busy_hi)) begin
      base = {addr[AW-1:2], 4'h0};
      if (BUF_EN && tag_valid && tag == addr[AW-1:2]) begin
        e.cyc  = cyc + 1;
        e.data = held_line;
        rq.push_back(e);
        m.cyc  = cyc + 1;
        m.addr = last_a;
        aq.push_back(m);
        busy_lo = cyc + 1;
        busy_hi = cyc + 1;
      end else begin
        e.cyc  = cyc + NB + 2;
        e.data = line_of(base);
        rq.push_back(e);
        for (int k = 0; k <= NB; k++) begin
          m.cyc  = cyc + 1 + k;
          m.addr = base + MAW'((k < NB) ? k : NB - 1);
          aq.push_back(m);
        end
        busy_lo   = cyc + 1;
        busy_hi   = cyc + NB + 2;
        tag_valid = 1'b1;
        tag       = addr[AW-1:2];
        held_line = e.data;
        last_a    = base + MAW'(NB - 1);
      end
    end
    tick(1);
    req_valid = 1'b0;
    rdy       = 1'b1;
  endtask

  // Monitor: compares busy, the RAM address trace and responses every cycle
  always @(negedge clk) begin : monitor
    resp_t e;
    if (rst) begin
      prev_rv = 1'b0;
    end else begin
      check("busy", LW'(busy), LW'(cyc >= busy_lo && cyc <= busy_hi));
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        check("mem_a", LW'(mem_a), LW'(aq[0].addr));
        void'(aq.pop_front());
      end
      if (resp_valid) begin
        check("resp_valid_consecutive", LW'(prev_rv), '0);
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp at cycle %0d: resp_valid=1, expected no response", cyc);
        end else begin
          e = rq.pop_front();
          check("resp_cycle", LW'(cyc), LW'(e.cyc));
          check("resp_data", resp_data, e.data);
        end
      end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout at cycle %0d: no resp_valid, expected one at cycle %0d",
                 cyc, rq[0].cyc);
        void'(rq.pop_front());
      end
      prev_rv = resp_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] last_req;
    logic          r;
    int            c0;
    int            t;

    // Reset state
    tick(3);
    check("reset_resp_valid", LW'(resp_valid), '0);
    check("reset_resp_data", resp_data, '0);
    check("reset_busy", LW'(busy), '0);
    check("reset_mem_a", LW'(mem_a), '0);
    rst = 1'b0;
    tick(1);

    // Basic refill, same line via other words, top-of-memory line
    issue(17'h00005, 1'b1); wait_idle(2);
    issue(17'h00007, 1'b1); wait_idle(0);
    issue(17'h00004, 1'b1); wait_idle(2);
    issue(17'h1FFFF, 1'b1); wait_idle(2);

    // Request while busy is ignored
    issue(17'h00040, 1'b1);
    tick(4);
    issue(17'h00123, 1'b1);
    wait_idle(2);

    // Reset in cycle 9 of a refill aborts it
    issue(17'h00100, 1'b1);
    tick(8);
    rst = 1'b1;
    model_reset();
    tick(1);
    rst = 1'b0;
    check("abort_resp_data", resp_data, '0);
    check("abort_busy", LW'(busy), '0);
    check("abort_mem_a", LW'(mem_a), '0);
    check("abort_resp_valid", LW'(resp_valid), '0);
    tick(25);
    issue(17'h00100, 1'b1); wait_idle(2);

    // rdy low in IDLE drops the request; rdy low during READ is ignored
    issue(17'h00200, 1'b0);
    tick(5);
    issue(17'h00300, 1'b1);
    tick(2);
    rdy = 1'b0;
    tick(4);
    rdy = 1'b1;
    wait_idle(2);

    // Repeat of the same line (buffer hit when the feature is built in)
    issue(17'h00005, 1'b1); wait_idle(2);
    issue(17'h00005, 1'b1); wait_idle(2);

    // Randomized traffic
    last_req = 17'h00005;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       a = {last_req[AW-1:2], 2'($urandom)};
        1:       a = AW'($urandom);
        default: a = {15'h7FFF, 2'($urandom)};
      endcase
      if ($urandom_range(0, 5) == 0) salt = 8'($urandom);
      r  = ($urandom_range(0, 4) != 0);
      c0 = cyc;
      issue(a, r);
      if (r) last_req = a;
      if (busy_hi >= cyc && busy_lo == c0 + 1 && $urandom_range(0, 1) == 1) begin
        t = $urandom_range(cyc, busy_hi);
        while (cyc < t) tick(1);
        issue(AW'($urandom), 1'b1);
      end
      wait_idle($urandom_range(0, 3));
    end

    tick(30);
    check("pending_responses", LW'(rq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
